// File: rtl/uart_pkg.sv
// Shared FSM state encoding and framing constants for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP,
        PARITY
    } state_t;

    localparam int   IDLE_DWELL = 2;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, phase restarted by clear.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the synchronous FIFO read port and serialises them LSB first as 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
    localparam logic [1:0]       DWELL_DONE = 2'(IDLE_DWELL);

    state_t           state, state_next;
    logic [WIDTH-1:0] shift, shift_next;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_next;
    logic [1:0]       dwell, dwell_next;
    logic             tx_next, rd_en_next, busy_next;
    logic             baud_clear, tick;

`ifdef UART_TX_PARITY_EN
    logic parity, parity_next;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        dwell_next   = dwell;
        baud_clear   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity;
`endif
        case (state)
            IDLE: begin
                // Dwell lets the FIFO empty flag settle after the previous pop.
                baud_clear = 1'b1;
                dwell_next = (dwell == DWELL_DONE) ? dwell : dwell + 2'd1;
                if (dwell_next == DWELL_DONE && enable && !fifo_empty) begin
                    state_next = POP;
                end
            end
            POP: begin
                baud_clear = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                baud_clear   = 1'b1;
                shift_next   = fifo_dout;
                bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                parity_next  = even_parity(fifo_dout);
`endif
                state_next   = START;
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    dwell_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        rd_en_next = (state_next == POP);
        busy_next  = (state_next != IDLE);
        case (state_next)
            START:   tx_next = START_BIT;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            dwell      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_rd_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_cnt    <= bit_cnt_next;
            dwell      <= dwell_next;
            tx         <= tx_next;
            busy       <= busy_next;
            fifo_rd_en <= rd_en_next;
`ifdef UART_TX_PARITY_EN
            parity     <= parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench for fifo_uart_tx: FIFO model feeds bytes, a UART receiver model decodes the line.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int W   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = W + 3;
`else
    localparam int NB  = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         fifo_empty;
    logic [W-1:0] fifo_dout;
    logic         fifo_rd_en;
    logic         tx;
    logic         busy;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] fifo_q[$];
    int pops      = 0;
    int busy_cnt  = 0;
    int underflow = 0;
    bit pop_pend;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .WIDTH       (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // FIFO read-side model: data valid the cycle after a pop, flag follows contents.
    always begin
        @(negedge clk);
        pop_pend = (fifo_rd_en === 1'b1);
        if (pop_pend) pops++;
        if (busy === 1'b1) busy_cnt++;
        @(posedge clk);
        #1;
        if (pop_pend) begin
            if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            else underflow++;
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Receiver model: waits for a start bit, then decodes one frame sampled every cycle.
    task automatic expect_frame(input string tag, input logic [7:0] exp_byte, input int min_gap);
        int         gap = 0;
        int         waited = 0;
        int         unstable = 0;
        int         side_bad = 0;
        logic [1:0] rd_h = '0;
        logic [1:0] busy_h = '0;
        logic [NB-1:0] bits = '0;
        @(negedge clk);
        while (tx !== 1'b0 && waited < 300) begin
            if (tx === 1'b1) gap++;
            rd_h   = {rd_h[0], fifo_rd_en};
            busy_h = {busy_h[0], busy};
            waited++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            check_eq({tag, "_start_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, "_gap_ok"}, 32'(gap >= min_gap), 32'd1);
        check_eq({tag, "_pop_latency"}, 32'(rd_h), 32'd2);
        check_eq({tag, "_busy_pop_load"}, 32'(busy_h), 32'd3);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (c == 0) bits[b] = tx;
                else if (tx !== bits[b]) unstable++;
                if (busy !== 1'b1 || fifo_rd_en !== 1'b0) side_bad++;
            end
        end
        check_eq({tag, "_start_bit"}, 32'(bits[0]), 32'd0);
        check_eq({tag, "_data"}, 32'(bits[W:1]), 32'(exp_byte));
`ifdef UART_TX_PARITY_EN
        check_eq({tag, "_parity"}, 32'(bits[W+1]), 32'(^exp_byte));
`endif
        check_eq({tag, "_stop_bit"}, 32'(bits[NB-1]), 32'd1);
        check_eq({tag, "_bit_hold"}, 32'(unstable), 32'd0);
        check_eq({tag, "_busy_rd_in_frame"}, 32'(side_bad), 32'd0);
    endtask

    initial begin
        int         p0;
        int         b0;
        int         viol;
        logic [7:0] bytes[$];

        rst        = 1'b0;
        enable     = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = '0;

        // Reset and idle
        cycles(1);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        cycles(2);
        rst  = 1'b1;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) viol++;
        end
        check_eq("idle_empty_quiet", 32'(viol), 32'd0);
        check_eq("idle_no_pops", 32'(pops), 32'd0);

        // Single byte
        p0 = pops;
        b0 = busy_cnt;
        fifo_q.push_back(8'hA5);
        expect_frame("single_a5", 8'hA5, 0);
        cycles(10);
        check_eq("single_pops", 32'(pops - p0), 32'd1);
        check_eq("single_busy_len", 32'(busy_cnt - b0), 32'(2 + NB * CPB));

        // Burst of three, back to back
        p0 = pops;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h3C);
        expect_frame("burst0", 8'h00, 0);
        expect_frame("burst1", 8'hFF, 4);
        expect_frame("burst2", 8'h3C, 4);
        cycles(20);
        check_eq("burst_pops", 32'(pops - p0), 32'd3);
        check_eq("burst_idle_tx", 32'(tx), 32'd1);

        // Directed parity bytes plus random bytes, queued together
        p0 = pops;
        bytes = {8'h07, 8'h03};
        for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom_range(0, 255)));
        foreach (bytes[i]) fifo_q.push_back(bytes[i]);
        foreach (bytes[i]) expect_frame($sformatf("rand%0d", i), bytes[i], (i == 0) ? 0 : 4);
        cycles(10);
        check_eq("rand_pops", 32'(pops - p0), 32'(bytes.size()));

        // Enable dropped during the data bits of the first of two bytes
        p0 = pops;
        fifo_q.push_back(8'h96);
        fifo_q.push_back(8'h4B);
        fork
            expect_frame("en_first", 8'h96, 0);
            begin
                cycles(20);
                enable = 1'b0;
            end
        join
        cycles(40);
        check_eq("en_hold_pops", 32'(pops - p0), 32'd1);
        check_eq("en_hold_left", 32'(fifo_q.size()), 32'd1);
        check_eq("en_hold_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        expect_frame("en_second", 8'h4B, 0);

        // Reset in the middle of data bit 3 of 0x55
        p0 = pops;
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h66);
        viol = 0;
        while (tx !== 1'b0 && viol < 300) begin
            cycles(1);
            viol++;
        end
        check_eq("midrst_started", 32'(tx), 32'd0);
        cycles(4 * CPB + 1);
        check_eq("midrst_pre_tx", 32'(tx), 32'd0);
        rst = 1'b0;
        cycles(1);
        check_eq("midrst_tx", 32'(tx), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        cycles(1);
        rst = 1'b1;
        expect_frame("after_rst", 8'h66, 0);
        cycles(10);
        check_eq("midrst_pops", 32'(pops - p0), 32'd2);
        check_eq("fifo_drained", 32'(fifo_q.size()), 32'd0);
        check_eq("no_underflow", 32'(underflow), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drains bytes from the team's synchronous FIFO (8-bit, 16-deep) through its read side: rd_en in, dout/empty out.
- Serialises each byte onto a UART line: 8N1 by default, LSB first.
- Sits between the FIFO read port and the board TX pin.
- Completes the path on the read side: producer -> FIFO -> this block -> serial line.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 2.
- WIDTH, 8, data bits per frame; must match the FIFO WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  1 = start new frames when data is available; 0 = finish the current frame, then hold idle.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  single-cycle pop request to the FIFO.
- tx  out  1  serial line; idle high.
- busy  out  1  high from the POP cycle through the last STOP cycle.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, tx=1, busy=0, fifo_rd_en=0, shift reg=0, baud counter=0, bit counter=0, dwell counter=0.
- Reset asserted mid-frame: tx returns high on the same edge; the in-flight byte is dropped and not re-popped.
- All outputs are registered.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - tx=1, busy=0.
  - Dwell counter must reach 2 (>=2 cycles in IDLE) before a pop is allowed. This covers the FIFO flag update lag.
  - If dwell done, enable=1 and fifo_empty=0: go to POP.
- POP: fifo_rd_en=1 for exactly this one cycle; busy=1; go to LOAD.
- LOAD: capture fifo_dout into the shift register; clear the baud counter; go to START.
- START: tx=0 for CLKS_PER_BIT cycles; go to DATA.
- DATA:
  - tx = shift[0]; after CLKS_PER_BIT cycles, shift right by 1 and increment the bit counter.
  - After WIDTH bits, go to STOP (or PARITY).
- STOP: tx=1 for CLKS_PER_BIT cycles; go to IDLE with the dwell counter cleared.
- Latency: fifo_rd_en high in cycle N -> tx falls at the edge ending cycle N+1 (LOAD) -> tx low from N+2.
- Frame length (START through STOP): (WIDTH+2)*CLKS_PER_BIT cycles.
- Back-to-back frames: at least 2 idle-high cycles between a STOP end and the next POP cycle, so the gap between frames is 4 cycles (2 IDLE + POP + LOAD).
- enable dropped mid-frame: the current frame completes normally; no further pop.
- fifo_empty asserted during a frame: ignored until IDLE.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit counter: $clog2(WIDTH+1) bits.
- fifo_rd_en is never asserted outside POP, and never while fifo_empty=1 was sampled in IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = even parity (XOR of the captured WIDTH bits) for CLKS_PER_BIT cycles.
  - Frame length = (WIDTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; frame is 8N1.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, POP, LOAD, START, DATA, STOP, PARITY).
  - localparams IDLE_DWELL=2, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module baud_tick_gen (parameter CLKS_PER_BIT):
  - Inputs clk, rst, clear. Output tick: one-cycle pulse every CLKS_PER_BIT cycles, counted from clear.
  - The FSM stays in the top module.

Test Plan:
- Reset and idle: rst=0 for 3 cycles, then 1, with fifo_empty=1 -> tx=1, busy=0, fifo_rd_en=0 for 100 cycles.
- Single byte: CLKS_PER_BIT=4; FIFO holds 0xA5 -> exactly one fifo_rd_en pulse; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles; busy high for 2+40 cycles.
- Burst: FIFO holds 0x00, 0xFF, 0x3C -> exactly 3 pops; frames decode in order; each inter-frame gap >= 4 cycles; no duplicated or skipped byte.
- Enable gating: enable dropped to 0 during DATA of byte 1 with 2 bytes queued -> byte 1 completes; no second pop until enable=1.
- Reset mid-frame: rst=0 during bit 3 of 0x55 -> tx=1 next edge; after release, next pop sends the next FIFO byte, not 0x55.
- Parity (UART_TX_PARITY_EN defined, CLKS_PER_BIT=4): 0x07 -> parity bit 1; 0x03 -> parity bit 0; frame length 44 cycles.
